// File: rtl/emit_pkg.sv
// emit_pkg: state encoding and Moore output decode shared by the emit blocks.
package emit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_INIT  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_COUNT = 3'd4,
        ST_DONE  = 3'd5
    } emit_state_t;

    typedef struct packed {
        logic cnt_ld;
        logic cnt_clr;
        logic cnt_ack;
        logic count;
    } emit_out_t;

    localparam emit_out_t OUT_IDLE  = '{cnt_ld: 1'b0, cnt_clr: 1'b1, cnt_ack: 1'b0, count: 1'b0};
    localparam emit_out_t OUT_GRANT = '{cnt_ld: 1'b0, cnt_clr: 1'b1, cnt_ack: 1'b0, count: 1'b0};
    localparam emit_out_t OUT_INIT  = '{cnt_ld: 1'b1, cnt_clr: 1'b0, cnt_ack: 1'b0, count: 1'b0};
    localparam emit_out_t OUT_WAIT  = '{cnt_ld: 1'b1, cnt_clr: 1'b0, cnt_ack: 1'b1, count: 1'b0};
    localparam emit_out_t OUT_COUNT = '{cnt_ld: 1'b0, cnt_clr: 1'b0, cnt_ack: 1'b0, count: 1'b1};
    localparam emit_out_t OUT_DONE  = '{cnt_ld: 1'b0, cnt_clr: 1'b1, cnt_ack: 1'b0, count: 1'b0};

    // Illegal encodings decode like IDLE so the counter is held cleared.
    function automatic emit_out_t emit_decode(input emit_state_t st);
        case (st)
            ST_IDLE:  return OUT_IDLE;
            ST_GRANT: return OUT_GRANT;
            ST_INIT:  return OUT_INIT;
            ST_WAIT:  return OUT_WAIT;
            ST_COUNT: return OUT_COUNT;
            ST_DONE:  return OUT_DONE;
            default:  return OUT_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/emit_seq_ctrl_if.sv
// emit_seq_ctrl_if: front-end load bus plus pour-counter handshake.
// master = front end / pour counter side, slave = emit_seq_ctrl.
interface emit_seq_ctrl_if #(
    parameter int NCH = 4,
    parameter int CW  = 8
);
    localparam int IW = $clog2(NCH);

    logic [NCH-1:0]    load;
    logic [NCH*CW-1:0] cnt_val;
    logic              out_ctrl;
    logic              count_ack;
    logic              cnt_ld;
    logic              cnt_clr;
    logic              cnt_ack;
    logic              count;
    logic [IW-1:0]     emit_ch;
    logic [CW-1:0]     remaining;
    logic              busy;
    logic [NCH-1:0]    done;
    logic [NCH-1:0]    pending;

    modport master (
        output load, cnt_val, out_ctrl, count_ack,
        input  cnt_ld, cnt_clr, cnt_ack, count, emit_ch, remaining, busy, done, pending
    );

    modport slave (
        input  load, cnt_val, out_ctrl, count_ack,
        output cnt_ld, cnt_clr, cnt_ack, count, emit_ch, remaining, busy, done, pending
    );

endinterface

// File: rtl/emit_arb.sv
// emit_arb: combinational channel arbiter.
// Build option EMIT_RR_EN: round-robin starting after last_grant;
// otherwise fixed priority, lowest pending index wins.
module emit_arb
    import emit_pkg::*;
#(
    parameter  int NCH = 4,
    localparam int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] pending,
    input  logic [IW-1:0]  last_grant,
    output logic [IW-1:0]  grant,
    output logic           valid
);

`ifdef EMIT_RR_EN
    // Search last_grant+1 .. last_grant+NCH modulo NCH; first pending hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            idx = IW'((int'(last_grant) + k) % NCH);
            if (!valid && pending[idx]) begin
                grant = idx;
                valid = 1'b1;
            end
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    // Scan from the top down so the lowest pending index is the final winner.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (pending[i]) begin
                grant = IW'(i);
                valid = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/emit_seq_ctrl.sv
// emit_seq_ctrl: multi-channel emit sequencer in front of the shared pour counter.
// Build option EMIT_RR_EN selects round-robin arbitration (see emit_arb).
//
// state | meaning
// IDLE  | counter cleared, waiting for any pending channel
// GRANT | arbiter picks a channel, its count is copied into remaining
// INIT  | counter loaded, waiting for out_ctrl
// WAIT  | dose boundary; finish if remaining is zero
// COUNT | one dose requested, waiting for count_ack
// DONE  | counter cleared, done pulse for the served channel follows
module emit_seq_ctrl
    import emit_pkg::*;
#(
    parameter  int NCH = 4,
    parameter  int CW  = 8,
    localparam int IW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           RESET,
    emit_seq_ctrl_if.slave bus
);

    emit_state_t    state, state_nxt;
    emit_out_t      outs;
    logic [CW-1:0]  cnt_q [NCH];
    logic [NCH-1:0] pending_q;
    logic [NCH-1:0] done_q;
    logic [NCH-1:0] serve_mask;
    logic [IW-1:0]  emit_ch_q;
    logic [CW-1:0]  rem_q;
    logic [IW-1:0]  grant;
    logic           grant_vld;
    logic [IW-1:0]  last_grant;
    logic           granting;

    assign granting = (state == ST_GRANT) && grant_vld;

    emit_arb #(.NCH(NCH)) u_arb (
        .pending    (pending_q),
        .last_grant (last_grant),
        .grant      (grant),
        .valid      (grant_vld)
    );

`ifdef EMIT_RR_EN
    // Remember the last granted channel; reset value makes channel 0 first.
    always_ff @(posedge clk) begin
        if (RESET)
            last_grant <= IW'(NCH - 1);
        else if (granting)
            last_grant <= grant;
    end
`else
    assign last_grant = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (RESET)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; unknown encodings fall back to IDLE.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE:  state_nxt = (|pending_q) ? ST_GRANT : ST_IDLE;
            ST_GRANT: state_nxt = ST_INIT;
            ST_INIT:  state_nxt = bus.out_ctrl ? ST_WAIT : ST_INIT;
            ST_WAIT:  state_nxt = (rem_q == '0) ? ST_DONE : ST_COUNT;
            ST_COUNT: state_nxt = bus.count_ack ? ST_WAIT : ST_COUNT;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Channel whose loads are blocked: the one being granted or already in service.
    always_comb begin
        serve_mask = '0;
        if (granting)
            serve_mask[grant] = 1'b1;
        else if (state == ST_INIT || state == ST_WAIT || state == ST_COUNT || state == ST_DONE)
            serve_mask[emit_ch_q] = 1'b1;
    end

    // Per-channel request latch and dose count capture.
    always_ff @(posedge clk) begin
        if (RESET) begin
            pending_q <= '0;
            for (int i = 0; i < NCH; i++)
                cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.load[i] && !serve_mask[i]) begin
                    pending_q[i] <= 1'b1;
                    cnt_q[i]     <= bus.cnt_val[i*CW +: CW];
                end else if (granting && grant == IW'(i)) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    // Served channel, remaining-dose down-counter and done pulse.
    always_ff @(posedge clk) begin
        if (RESET) begin
            emit_ch_q <= '0;
            rem_q     <= '0;
            done_q    <= '0;
        end else begin
            done_q <= '0;
            case (state)
                ST_GRANT: begin
                    if (grant_vld) begin
                        emit_ch_q <= grant;
                        rem_q     <= cnt_q[grant];
                    end
                end
                ST_COUNT: begin
                    if (bus.count_ack && rem_q != '0)
                        rem_q <= rem_q - CW'(1);
                end
                ST_DONE:  done_q[emit_ch_q] <= 1'b1;
                default:  ;
            endcase
        end
    end

    // Moore output decode.
    always_comb begin
        outs = emit_decode(state);
    end

    assign bus.cnt_ld    = outs.cnt_ld;
    assign bus.cnt_clr   = outs.cnt_clr;
    assign bus.cnt_ack   = outs.cnt_ack;
    assign bus.count     = outs.count;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.emit_ch   = emit_ch_q;
    assign bus.remaining = rem_q;
    assign bus.done      = done_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_emit_seq_ctrl.sv
// tb_emit_seq_ctrl: directed self-checking bench for emit_seq_ctrl.
// Honours EMIT_RR_EN for the expected arbitration order.
module tb_emit_seq_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 8;

    // {busy, cnt_ld, cnt_clr, cnt_ack, count} per state
    localparam logic [4:0] O_IDLE  = 5'b00100;
    localparam logic [4:0] O_GRANT = 5'b10100;
    localparam logic [4:0] O_INIT  = 5'b11000;
    localparam logic [4:0] O_WAIT  = 5'b11010;
    localparam logic [4:0] O_COUNT = 5'b10001;
    localparam logic [4:0] O_DONE  = 5'b10100;

    logic clk = 1'b0;
    logic RESET;
    int   checks = 0;
    int   passes = 0;

    emit_seq_ctrl_if #(.NCH(NCH), .CW(CW)) bus ();

    emit_seq_ctrl #(.NCH(NCH), .CW(CW)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (bus)
    );

    logic [4:0] outs;
    assign outs = {bus.busy, bus.cnt_ld, bus.cnt_clr, bus.cnt_ack, bus.count};

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ch(input int ch, input logic [CW-1:0] val);
        bus.load = '0;
        bus.load[ch] = 1'b1;
        bus.cnt_val[ch*CW +: CW] = val;
        tick();
        bus.load = '0;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
        checks++; if (outs !== O_IDLE) $display("FAIL reset_outs: got %b want %b", outs, O_IDLE); else passes++;
        checks++; if (bus.pending !== 4'b0000) $display("FAIL reset_pending: got %b want 0000", bus.pending); else passes++;
        checks++; if (bus.remaining !== 8'd0) $display("FAIL reset_remaining: got %0d want 0", bus.remaining); else passes++;
        checks++; if (bus.emit_ch !== 2'd0) $display("FAIL reset_emit_ch: got %0d want 0", bus.emit_ch); else passes++;
        checks++; if (bus.done !== 4'b0000) $display("FAIL reset_done: got %b want 0000", bus.done); else passes++;
        tick();
        checks++; if (outs !== O_IDLE) $display("FAIL reset_stay_idle: got %b want %b", outs, O_IDLE); else passes++;
    endtask

    task automatic test_dose3();
        logic [4:0]    seq [11];
        logic [CW-1:0] wexp [4];
        logic [CW-1:0] wrem [$];
        logic [NCH-1:0] donev;
        int ncount, done_at;
        seq  = '{O_GRANT, O_INIT, O_WAIT, O_COUNT, O_WAIT, O_COUNT, O_WAIT, O_COUNT, O_WAIT, O_DONE, O_IDLE};
        wexp = '{8'd3, 8'd2, 8'd1, 8'd0};
        ncount = 0; done_at = -1; donev = '0;
        bus.out_ctrl = 1'b1; bus.count_ack = 1'b1;
        load_ch(2, 8'd3);
        checks++; if (bus.pending !== 4'b0100) $display("FAIL dose3_pending: got %b want 0100", bus.pending); else passes++;
        checks++; if (outs !== O_IDLE) $display("FAIL dose3_idle: got %b want %b", outs, O_IDLE); else passes++;
        for (int c = 0; c <= 10; c++) begin
            tick();
            checks++; if (outs !== seq[c]) $display("FAIL dose3_state c=%0d: got %b want %b", c, outs, seq[c]); else passes++;
            if (bus.count) ncount++;
            if (outs == O_WAIT) wrem.push_back(bus.remaining);
            if (bus.done != '0) begin done_at = c; donev = bus.done; end
            if (c == 1) begin
                checks++; if (bus.emit_ch !== 2'd2) $display("FAIL dose3_emit_ch: got %0d want 2", bus.emit_ch); else passes++;
                checks++; if (bus.pending !== 4'b0000) $display("FAIL dose3_pend_clr: got %b want 0000", bus.pending); else passes++;
            end
        end
        checks++; if (ncount != 3) $display("FAIL dose3_count_cycles: got %0d want 3", ncount); else passes++;
        checks++; if (done_at != 10) $display("FAIL dose3_done_cycle: got %0d want 10", done_at); else passes++;
        checks++; if (donev !== 4'b0100) $display("FAIL dose3_done_val: got %b want 0100", donev); else passes++;
        checks++; if (wrem.size() != 4) $display("FAIL dose3_wait_cnt: got %0d want 4", wrem.size()); else passes++;
        for (int i = 0; i < 4 && i < wrem.size(); i++) begin
            checks++; if (wrem[i] !== wexp[i]) $display("FAIL dose3_remaining[%0d]: got %0d want %0d", i, wrem[i], wexp[i]); else passes++;
        end
    endtask

    task automatic test_zero();
        logic [4:0] seq [5];
        int ncount, done_at;
        logic [NCH-1:0] donev;
        seq = '{O_GRANT, O_INIT, O_WAIT, O_DONE, O_IDLE};
        ncount = 0; done_at = -1; donev = '0;
        bus.out_ctrl = 1'b1; bus.count_ack = 1'b1;
        load_ch(0, 8'd0);
        for (int c = 0; c <= 4; c++) begin
            tick();
            checks++; if (outs !== seq[c]) $display("FAIL zero_state c=%0d: got %b want %b", c, outs, seq[c]); else passes++;
            if (bus.count) ncount++;
            if (bus.done != '0) begin done_at = c; donev = bus.done; end
        end
        checks++; if (ncount != 0) $display("FAIL zero_no_count: got %0d want 0", ncount); else passes++;
        checks++; if (done_at != 4) $display("FAIL zero_done_cycle: got %0d want 4", done_at); else passes++;
        checks++; if (donev !== 4'b0001) $display("FAIL zero_done_val: got %b want 0001", donev); else passes++;
    endtask

    task automatic test_arb();
        int order [$];
        int exp_ord [4];
        bit reloaded;
`ifdef EMIT_RR_EN
        exp_ord = '{0, 1, 3, 0};
`else
        exp_ord = '{0, 1, 0, 3};
`endif
        reloaded = 1'b0;
        bus.out_ctrl = 1'b1; bus.count_ack = 1'b1;
        bus.cnt_val = {8'd1, 8'd9, 8'd1, 8'd1};
        bus.load = 4'b1011;
        tick();
        bus.load = '0;
        checks++; if (bus.pending !== 4'b1011) $display("FAIL arb_pending: got %b want 1011", bus.pending); else passes++;
        for (int c = 0; c < 200 && order.size() < 4; c++) begin
            if (!reloaded && outs == O_INIT && bus.emit_ch == 2'd1) begin
                reloaded = 1'b1;
                load_ch(0, 8'd1);
                checks++; if (bus.pending !== 4'b1001) $display("FAIL arb_reload_pending: got %b want 1001", bus.pending); else passes++;
            end else begin
                tick();
            end
            for (int b = 0; b < NCH; b++)
                if (bus.done[b]) order.push_back(b);
        end
        checks++; if (order.size() != 4) $display("FAIL arb_done_count: got %0d want 4", order.size()); else passes++;
        for (int i = 0; i < 4 && i < order.size(); i++) begin
            checks++; if (order[i] != exp_ord[i]) $display("FAIL arb_order[%0d]: got %0d want %0d", i, order[i], exp_ord[i]); else passes++;
        end
        tick();
    endtask

    task automatic test_stall();
        bus.out_ctrl = 1'b0; bus.count_ack = 1'b0;
        load_ch(1, 8'd1);
        tick();
        tick();
        checks++; if (outs !== O_INIT) $display("FAIL stall_init: got %b want %b", outs, O_INIT); else passes++;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (outs !== O_INIT) $display("FAIL stall_init_hold %0d: got %b want %b", i, outs, O_INIT); else passes++;
            checks++; if (bus.remaining !== 8'd1) $display("FAIL stall_init_rem %0d: got %0d want 1", i, bus.remaining); else passes++;
        end
        bus.out_ctrl = 1'b1;
        tick();
        bus.out_ctrl = 1'b0;
        checks++; if (outs !== O_WAIT) $display("FAIL stall_wait: got %b want %b", outs, O_WAIT); else passes++;
        tick();
        checks++; if (outs !== O_COUNT) $display("FAIL stall_count: got %b want %b", outs, O_COUNT); else passes++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (outs !== O_COUNT) $display("FAIL stall_count_hold %0d: got %b want %b", i, outs, O_COUNT); else passes++;
            checks++; if (bus.remaining !== 8'd1) $display("FAIL stall_count_rem %0d: got %0d want 1", i, bus.remaining); else passes++;
        end
        bus.count_ack = 1'b1;
        tick();
        bus.count_ack = 1'b0;
        checks++; if (outs !== O_WAIT) $display("FAIL stall_ack_wait: got %b want %b", outs, O_WAIT); else passes++;
        checks++; if (bus.remaining !== 8'd0) $display("FAIL stall_ack_rem: got %0d want 0", bus.remaining); else passes++;
        tick();
        checks++; if (outs !== O_DONE) $display("FAIL stall_done_state: got %b want %b", outs, O_DONE); else passes++;
        tick();
        checks++; if (bus.done !== 4'b0010) $display("FAIL stall_done: got %b want 0010", bus.done); else passes++;
        tick();
    endtask

    task automatic test_ignore_load();
        bus.out_ctrl = 1'b1; bus.count_ack = 1'b0;
        load_ch(1, 8'd5);
        repeat (4) tick();
        checks++; if (outs !== O_COUNT) $display("FAIL ign_count: got %b want %b", outs, O_COUNT); else passes++;
        checks++; if (bus.remaining !== 8'd5) $display("FAIL ign_rem_pre: got %0d want 5", bus.remaining); else passes++;
        load_ch(1, 8'd7);
        checks++; if (bus.pending !== 4'b0000) $display("FAIL ign_pending: got %b want 0000", bus.pending); else passes++;
        checks++; if (bus.remaining !== 8'd5) $display("FAIL ign_rem_post: got %0d want 5", bus.remaining); else passes++;
        bus.count_ack = 1'b1;
        tick();
        bus.count_ack = 1'b0;
        checks++; if (bus.remaining !== 8'd4) $display("FAIL ign_rem_dec: got %0d want 4", bus.remaining); else passes++;
        apply_reset();
    endtask

    task automatic test_reset_mid();
        bus.out_ctrl = 1'b1; bus.count_ack = 1'b0;
        load_ch(1, 8'd3);
        repeat (4) tick();
        load_ch(2, 8'd4);
        checks++; if (outs !== O_COUNT) $display("FAIL rmid_count: got %b want %b", outs, O_COUNT); else passes++;
        checks++; if (bus.remaining !== 8'd3) $display("FAIL rmid_rem_pre: got %0d want 3", bus.remaining); else passes++;
        checks++; if (bus.pending !== 4'b0100) $display("FAIL rmid_pend_pre: got %b want 0100", bus.pending); else passes++;
        apply_reset();
        checks++; if (outs !== O_IDLE) $display("FAIL rmid_idle: got %b want %b", outs, O_IDLE); else passes++;
        checks++; if (bus.pending !== 4'b0000) $display("FAIL rmid_pending: got %b want 0000", bus.pending); else passes++;
        checks++; if (bus.remaining !== 8'd0) $display("FAIL rmid_rem: got %0d want 0", bus.remaining); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.done !== 4'b0000) $display("FAIL rmid_no_done %0d: got %b want 0000", i, bus.done); else passes++;
            tick();
            checks++; if (outs !== O_IDLE) $display("FAIL rmid_stay_idle %0d: got %b want %b", i, outs, O_IDLE); else passes++;
        end
    endtask

    initial begin
        RESET         = 1'b1;
        bus.load      = '0;
        bus.cnt_val   = '0;
        bus.out_ctrl  = 1'b0;
        bus.count_ack = 1'b0;
        test_reset();
        test_dose3();
        test_zero();
        test_arb();
        test_stall();
        test_ignore_load();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
